simon_seq_checker: RTL and testbench
====================================

# simon_seq_checker

Parametrised sequence checker for the Simon game datapath. It stores the colour sequence produced by the pattern generator, up to MAX_LEN entries. It then checks one round of player presses against that sequence, press by press, and reports pass, fail or timeout with a registered result code. It sits between the pattern generator, the debounced button decoder and the game-control FSM.

## Interface
- COLOR_W, 2: bits per colour code
- MAX_LEN, 32: maximum stored sequence length; power of two not required, must be ≥1
- LEN_W, 6: width of length/index; must satisfy 2^LEN_W > MAX_LEN
- TIMEOUT_CYC, 50_000_000: per-press timeout in clk cycles; used only with SIMON_TIMEOUT_EN

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear: empties sequence, aborts round
- push_valid  in  1  append request
- push_color  in  COLOR_W  colour to append
- push_ready  out  1  append accepted when push_valid && push_ready
- start  in  1  begin checking a round against the full stored sequence
- in_valid  in  1  player press strobe
- in_color  in  COLOR_W  pressed colour
- in_ready  out  1  press accepted when in_valid && in_ready
- press_ok  out  1  one-cycle pulse: accepted press matched, round not finished
- result  out  2  00 none, 01 pass, 10 fail, 11 timeout
- result_valid  out  1  one-cycle pulse when result is updated
- length  out  LEN_W  number of stored entries
- busy  out  1  high while a round is being checked

## Operation
- Storage: register array of MAX_LEN × COLOR_W, written at index length on an accepted push, then length increments. The array is not reset; only length is.
- push_ready = (state==IDLE) && (length<MAX_LEN) && !start && !clear.
- A push while full or busy is dropped silently.
- FSM states:
  - IDLE: start with length>0 → CHECK, idx←0, timer←0. Start with length==0 is ignored.
  - CHECK: in_ready=1, busy=1.
    - Accepted press with in_color==mem[idx] and idx==length−1 → DONE, result←01.
    - Match otherwise: idx←idx+1, press_ok pulse, stay in CHECK.
    - Mismatch → DONE, result←10. Remaining entries are not checked.
  - DONE: result_valid=1 for exactly this cycle, busy=0, in_ready=0 → IDLE.
- result holds its value until the next accepted start (→00) or clear (→00).
- clear has priority over every other input in every state:
  - length←0, result←00, state←IDLE.
  - No result_valid is generated.
- start while in CHECK or DONE is ignored.
- in_valid outside CHECK is ignored.

## Timing
- Reset values: state IDLE, length 0, idx 0, result 00, result_valid 0, press_ok 0, busy 0, in_ready 0. push_ready is 1 once reset deasserts and start/clear are low.
- Push accepted at edge N: length updates at N+1 and a start at N+1 checks the new entry.
- start accepted at edge N: busy and in_ready are high from N+1.
- Press accepted at edge N: press_ok (match) or result_valid (final/mismatch) is high for the cycle after N. The next press can be accepted at N+1 on a non-final match.
- Final press at edge N: result updates at N+1, result_valid high N+1 only, IDLE and push_ready from N+2.
- Reset assertion mid-round: everything returns to reset values immediately; stored entries are lost because length becomes 0.
- idx never exceeds length−1; there is no wrap-around of idx. length saturates at MAX_LEN.

## Configuration
- SIMON_TIMEOUT_EN defined:
  - A LEN-independent counter, 32 bits, runs in CHECK and resets to 0 on each accepted press and on start.
  - When it reaches TIMEOUT_CYC−1 with no press accepted that cycle → DONE, result←11.
  - An accepted press in the same cycle wins over the timeout.
- SIMON_TIMEOUT_EN undefined: no counter is built, CHECK waits indefinitely, and result 11 is never produced.

## Test plan
- Reset, push 3 colours (2,0,3), start, press 2,0,3 back-to-back → press_ok on presses 1–2, result=01 with a single result_valid pulse the cycle after press 3, length stays 3.
- Sequence (1,1,2), presses 1,3 → press_ok once, result=10 after second press, third press ignored (in_ready=0).
- Push MAX_LEN entries, then a further push → push_ready=0, length=MAX_LEN, no array overwrite. Start then covers all MAX_LEN entries → 01.
- Assert clear during CHECK after one correct press → result=00, length=0, busy=0 next cycle, no result_valid. Start with length 0 → stays IDLE.
- start and push_valid high together in IDLE with length 2 → push dropped, round checks 2 entries. Reset asserted mid-round → all outputs at reset values immediately.
- With SIMON_TIMEOUT_EN and TIMEOUT_CYC=8, start then no presses → result=11 eight cycles after CHECK entry. A press arriving on the timeout cycle is processed and the timeout is suppressed.

Source files
------------

// File: rtl/simon_seq_checker.sv
// simon_seq_checker: stores a Simon colour sequence and checks a round of presses.
// Optional per-press timeout built when SIMON_TIMEOUT_EN is defined.
module simon_seq_checker #(
  parameter int COLOR_W     = 2,
  parameter int MAX_LEN     = 32,
  parameter int LEN_W       = 6,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               push_valid,
  input  logic [COLOR_W-1:0] push_color,
  output logic               push_ready,
  input  logic               start,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] in_color,
  output logic               in_ready,
  output logic               press_ok,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [LEN_W-1:0]   length,
  output logic               busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [1:0]         res_q, res_d;
  logic               pok_q, pok_d;
  logic [COLOR_W-1:0] mem [MAX_LEN];

  logic push_fire;
  logic in_fire;
  logic hit;
  logic last;

`ifdef SIMON_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;
  logic        tmo;
  assign tmo = (tmr_q == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign push_ready = (state_q == IDLE)
                   && (len_q < LEN_W'(MAX_LEN))
                   && !start && !clear;
  assign in_ready     = (state_q == CHECK);
  assign busy         = (state_q == CHECK);
  assign result_valid = (state_q == DONE);
  assign press_ok     = pok_q;
  assign result       = res_q;
  assign length       = len_q;

  assign push_fire = push_valid && push_ready;
  assign in_fire   = in_valid && in_ready;
  assign hit       = (in_color == mem[idx_q[AW-1:0]]);
  assign last      = (idx_q == len_q - LEN_W'(1));

  // Sequence storage; contents are don't-care beyond length.
  always_ff @(posedge clk) begin
    if (push_fire) mem[len_q[AW-1:0]] <= push_color;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      res_q   <= 2'b00;
      pok_q   <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      pok_q   <= pok_d;
`ifdef SIMON_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    res_d   = res_q;
    pok_d   = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif
    if (clear) begin
      state_d = IDLE;
      len_d   = '0;
      idx_d   = '0;
      res_d   = 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (len_q != '0)) begin
            state_d = CHECK;
            idx_d   = '0;
            res_d   = 2'b00;
`ifdef SIMON_TIMEOUT_EN
            tmr_d   = '0;
`endif
          end else if (push_fire) begin
            len_d = len_q + LEN_W'(1);
          end
        end
        CHECK: begin
          if (in_fire) begin
`ifdef SIMON_TIMEOUT_EN
            tmr_d = '0;
`endif
            if (hit && last) begin
              state_d = DONE;
              res_d   = 2'b01;
            end else if (hit) begin
              idx_d = idx_q + LEN_W'(1);
              pok_d = 1'b1;
            end else begin
              state_d = DONE;
              res_d   = 2'b10;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (tmo) begin
            state_d = DONE;
            res_d   = 2'b11;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
`endif
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq_checker.sv
// tb_simon_seq_checker: directed and random stimulus against a queue model.
// Timeout scenarios are exercised when SIMON_TIMEOUT_EN is defined.
module tb_simon_seq_checker;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clear;
  logic       push_valid;
  logic [1:0] push_color;
  logic       push_ready;
  logic       start;
  logic       in_valid;
  logic [1:0] in_color;
  logic       in_ready;
  logic       press_ok;
  logic [1:0] result;
  logic       result_valid;
  logic [LW-1:0] length;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: stored colours plus round progress
  logic [1:0] q[$];
  bit m_act;
  bit m_done;
  bit m_ok;
  int m_pos;
  int m_res;
  int m_idle;

  simon_seq_checker #(
    .COLOR_W(2), .MAX_LEN(ML), .LEN_W(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .push_valid(push_valid), .push_color(push_color),
    .push_ready(push_ready), .start(start),
    .in_valid(in_valid), .in_color(in_color),
    .in_ready(in_ready), .press_ok(press_ok),
    .result(result), .result_valid(result_valid),
    .length(length), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_act = 0; m_done = 0; m_ok = 0;
    m_pos = 0; m_res = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit clr, st, pv, input logic [1:0] pc,
                            input bit iv, input logic [1:0] ic);
    bit n_done = 0;
    bit n_ok = 0;
    if (clr) begin
      q.delete();
      m_res = 0; m_act = 0;
    end else if (m_done) begin
    end else if (m_act) begin
      if (iv) begin
        m_idle = 0;
        if (ic != q[m_pos]) begin
          m_act = 0; n_done = 1; m_res = 2;
        end else if (m_pos == q.size() - 1) begin
          m_act = 0; n_done = 1; m_res = 1;
        end else begin
          m_pos++; n_ok = 1;
        end
      end else begin
`ifdef SIMON_TIMEOUT_EN
        if (m_idle == TO - 1) begin
          m_act = 0; n_done = 1; m_res = 3;
        end else m_idle++;
`endif
      end
    end else begin
      if (st && q.size() > 0) begin
        m_act = 1; m_pos = 0; m_res = 0; m_idle = 0;
      end else if (pv && !st && q.size() < ML) begin
        q.push_back(pc);
      end
    end
    m_done = n_done;
    m_ok = n_ok;
  endtask

  task automatic step(input bit clr, st, pv, input logic [1:0] pc,
                      input bit iv, input logic [1:0] ic);
    clear = clr; start = st;
    push_valid = pv; push_color = pc;
    in_valid = iv; in_color = ic;
    #1;
    check("push_ready", push_ready,
          int'(!m_act && !m_done && q.size() < ML && !clr && !st));
    check("in_ready", in_ready, int'(m_act));
    model_step(clr, st, pv, pc, iv, ic);
    @(posedge clk);
    #1;
    check("busy", busy, int'(m_act));
    check("result_valid", result_valid, int'(m_done));
    check("press_ok", press_ok, int'(m_ok));
    check("result", result, m_res);
    check("length", length, q.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic push(input logic [1:0] c);
    step(0, 0, 1, c, 0, 2'd0);
  endtask

  task automatic press(input logic [1:0] c);
    step(0, 0, 0, 2'd0, 1, c);
  endtask

  task automatic go();
    step(0, 1, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_press_ok", press_ok, 0);
    check("rst_length", length, 0);
  endtask

  task automatic do_reset();
    clear = 0; start = 0; push_valid = 0; in_valid = 0;
    resetn = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    int lvl;
    logic [1:0] ic;
    resetn = 1'b0;
    clear = 0; start = 0; push_valid = 0;
    push_color = 0; in_valid = 0; in_color = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    resetn = 1'b1;
    #1;
    check("rst_push_ready", push_ready, 1);

    push(2); push(0); push(3);
    go();
    press(2); press(0); press(3);
    idle(2);

    step(1, 0, 0, 2'd0, 0, 2'd0);
    push(1); push(1); push(2);
    go();
    press(1); press(3); press(1);
    idle(1);

    step(1, 0, 0, 2'd0, 0, 2'd0);
    for (int i = 0; i < ML + 1; i++) push(2'($urandom_range(0, 3)));
    push(2'd1);
    go();
    for (int i = 0; i < ML; i++) press(q[i]);
    idle(2);

    go();
    press(q[0]);
    step(1, 0, 0, 2'd0, 0, 2'd0);
    idle(1);
    go();
    idle(2);

    push(3); push(1);
    step(0, 1, 1, 2'd2, 0, 2'd0);
    press(3); press(1);
    idle(1);

    go();
    press(3);
    do_reset();
    idle(1);

`ifdef SIMON_TIMEOUT_EN
    push(1); push(2);
    go();
    idle(TO + 3);
    go();
    idle(TO - 1);
    press(1);
    idle(TO - 1);
    press(2);
    idle(2);
`endif

    lvl = 7;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) lvl = (lvl == 7) ? 1 : 7;
      if (m_act && $urandom_range(0, 9) < 9) ic = q[m_pos];
      else ic = 2'($urandom_range(0, 3));
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 2,
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < lvl,
           ic);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
